// File: rtl/pulse_sequencer.sv
// pulse_sequencer: frame divider, volume envelope and length counter for the
// pulse channel. Register values come from the serial register decoder.
// A toggle on reg_change means "register 4003 was written": it reloads the
// length counter from the length table and restarts the envelope.
module pulse_sequencer #(
  parameter int unsigned FRAME_DIV = 3728
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] reg_4000,
  input  logic [7:0] reg_4003,
  input  logic       reg_change,
  input  logic       enable,
  output logic       quarter_frame,
  output logic       half_frame,
  output logic [7:0] length_count,
  output logic [3:0] volume
);

  // Last value of the frame divider before it wraps.
  localparam logic [15:0] DIV_LAST = 16'(FRAME_DIV - 1);

  // Length table, indexed by reg_4003[7:3].
  function automatic logic [7:0] length_lookup(input logic [4:0] idx);
    logic [7:0] len;
    len = 8'd0;
    case (idx)
      5'd0:  len = 8'd10;
      5'd1:  len = 8'd254;
      5'd2:  len = 8'd20;
      5'd3:  len = 8'd2;
      5'd4:  len = 8'd40;
      5'd5:  len = 8'd4;
      5'd6:  len = 8'd80;
      5'd7:  len = 8'd6;
      5'd8:  len = 8'd160;
      5'd9:  len = 8'd8;
      5'd10: len = 8'd60;
      5'd11: len = 8'd10;
      5'd12: len = 8'd14;
      5'd13: len = 8'd12;
      5'd14: len = 8'd26;
      5'd15: len = 8'd14;
      5'd16: len = 8'd12;
      5'd17: len = 8'd16;
      5'd18: len = 8'd24;
      5'd19: len = 8'd18;
      5'd20: len = 8'd48;
      5'd21: len = 8'd20;
      5'd22: len = 8'd96;
      5'd23: len = 8'd22;
      5'd24: len = 8'd192;
      5'd25: len = 8'd24;
      5'd26: len = 8'd72;
      5'd27: len = 8'd26;
      5'd28: len = 8'd16;
      5'd29: len = 8'd28;
      5'd30: len = 8'd32;
      5'd31: len = 8'd30;
    endcase
    return len;
  endfunction

  // Register field aliases.
  logic       loop_flag;
  logic       const_vol;
  logic [3:0] env_period;
  logic [4:0] length_idx;

  assign loop_flag  = reg_4000[5];
  assign const_vol  = reg_4000[4];
  assign env_period = reg_4000[3:0];
  assign length_idx = reg_4003[7:3];

  // Register bits that this block does not use.
  logic unused_reg_bits;
  assign unused_reg_bits = ^{reg_4000[7:6], reg_4003[2:0]};

  // State flops.
  logic [15:0] div_q, div_d;
  logic [1:0]  step_q, step_d;
  logic        s1_q, s1_d;
  logic        s2_q, s2_d;
  logic        s3_q, s3_d;
  logic        start_q, start_d;
  logic [3:0]  decay_q, decay_d;
  logic [3:0]  ediv_q, ediv_d;
  logic [7:0]  length_q, length_d;

  // Combinational events derived from state.
  logic quarter_tick;
  logic half_tick;
  logic load;

  // Frame divider: count 0..FRAME_DIV-1 and advance the 4-step sequence on wrap.
  always_comb begin
    quarter_tick = (div_q == DIV_LAST);
    half_tick    = quarter_tick && step_q[0];
    div_d        = quarter_tick ? 16'd0 : div_q + 16'd1;
    step_d       = quarter_tick ? step_q + 2'd1 : step_q;
  end

  // Toggle detect: s1 absorbs metastability, s2^s3 marks one cycle per write.
  always_comb begin
    s1_d = reg_change;
    s2_d = s1_q;
    s3_d = s2_q;
    load = s2_q ^ s3_q;
  end

  // Envelope: restart, divide by (period+1), decay 15..0 with optional loop.
  // A restart requested on a quarter-frame cycle waits for the next one.
  always_comb begin
    start_d = start_q;
    decay_d = decay_q;
    ediv_d  = ediv_q;
    if (quarter_tick) begin
      if (start_q) begin
        start_d = 1'b0;
        decay_d = 4'hF;
        ediv_d  = env_period;
      end else if (ediv_q == 4'd0) begin
        ediv_d = env_period;
        if (decay_q != 4'd0) begin
          decay_d = decay_q - 4'd1;
        end else if (loop_flag) begin
          decay_d = 4'hF;
        end
      end else begin
        ediv_d = ediv_q - 4'd1;
      end
    end
    if (load) begin
      start_d = 1'b1;
    end
  end

  // Length counter: disable clears, load beats a same-cycle decrement, halt freezes.
  always_comb begin
    length_d = length_q;
    if (!enable) begin
      length_d = 8'd0;
    end else if (load) begin
      length_d = length_lookup(length_idx);
    end else if (half_tick && (length_q != 8'd0) && !loop_flag) begin
      length_d = length_q - 8'd1;
    end
  end

  // State update with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= 16'd0;
      step_q   <= 2'd0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      start_q  <= 1'b0;
      decay_q  <= 4'd0;
      ediv_q   <= 4'd0;
      length_q <= 8'd0;
    end else begin
      div_q    <= div_d;
      step_q   <= step_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      start_q  <= start_d;
      decay_q  <= decay_d;
      ediv_q   <= ediv_d;
      length_q <= length_d;
    end
  end

  // Outputs: ticks and gated volume straight from registered state, no extra stage.
  always_comb begin
    quarter_frame = quarter_tick;
    half_frame    = half_tick;
    length_count  = length_q;
    volume        = 4'd0;
    if (enable && (length_q != 8'd0)) begin
      volume = const_vol ? env_period : decay_q;
    end
  end

endmodule
